// File: rtl/inst_fetch_bridge_pkg.sv
// inst_fetch_bridge_pkg: shared types and constants for the instruction fetch bridge
package inst_fetch_bridge_pkg;
  typedef enum logic [1:0] {FAULT_NONE, FAULT_MISALIGN, FAULT_BUS, FAULT_TIMEOUT} fetchFault_e;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DISCARD} ifbState_e;
  localparam logic [31:0] INST_NOP = 32'h00000013;
endpackage

// File: rtl/inst_fetch_bridge_watchdog.sv
// ifb_watchdog: saturating bus-wait counter that flags expiry on the last allowed cycle
module ifb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] MAX = W'(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (enable && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
  // Expiry fires during the TIMEOUT-th busy cycle so the fault lands right after it
  assign expire = TIMEOUT != 0 && enable && cnt_q >= LAST;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (clk_en) cnt_q <= cnt_d;
  end
endmodule

// File: rtl/inst_fetch_bridge.sv
// inst_fetch_bridge: single-outstanding fetch-port to valid/ready instruction bus bridge
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_rd_en,
  input  logic              inst_ack,
  input  logic              abort,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ready,
  output logic              inst_fault,
  output logic [1:0]        fault_cause,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err
);
  ifbState_e state_q, state_d;
  fetchFault_e cause_q, cause_d;
  logic [ADDR_W-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d, rd_addr;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, ready_q, ready_d, fault_q, fault_d;
  logic discard_q, discard_d, pend_q, pend_d, proto_err_q, proto_err_d;
  logic busy, expire, rd_ok, rd_bad;
  assign rd_addr = {inst_addr[ADDR_W-1:2], 2'b00};
  assign rd_ok = inst_rd_en && inst_addr[1:0] == 2'b00;
  assign rd_bad = inst_rd_en && inst_addr[1:0] != 2'b00;
  assign busy = state_q == WAIT || state_q == DISCARD;
  ifb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clear  (!busy),
    .enable (busy),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    pend_addr_d = pend_addr_q;
    data_d = data_q;
    valid_d = valid_q;
    ready_d = ready_q;
    fault_d = fault_q;
    cause_d = cause_q;
    discard_d = discard_q;
    pend_d = pend_q;
    proto_err_d = proto_err_q | (mem_rsp_valid && !busy);
    case (state_q)
      IDLE: begin
        if (rd_bad) begin
          state_d = HOLD;
          ready_d = 1'b1;
          fault_d = 1'b1;
          cause_d = FAULT_MISALIGN;
          data_d = DATA_W'(INST_NOP);
        end else if (rd_ok) begin
          state_d = REQ;
          addr_d = rd_addr;
          valid_d = 1'b1;
        end
      end
      REQ: begin
        // The request is never withdrawn; an abort only marks its response for discard
        discard_d = discard_q | abort;
        if (mem_req_ready) begin
          valid_d = 1'b0;
          discard_d = 1'b0;
          state_d = (discard_q || abort) ? DISCARD : WAIT;
        end
      end
      WAIT: begin
        if (abort) state_d = mem_rsp_valid ? IDLE : DISCARD;
        else if (mem_rsp_valid) begin
          state_d = HOLD;
          ready_d = 1'b1;
          data_d = mem_rsp_data;
          fault_d = mem_rsp_err;
          cause_d = mem_rsp_err ? FAULT_BUS : FAULT_NONE;
        end else if (expire) begin
          state_d = HOLD;
          ready_d = 1'b1;
          fault_d = 1'b1;
          cause_d = FAULT_TIMEOUT;
          data_d = DATA_W'(INST_NOP);
        end
      end
      HOLD: begin
        if (abort || inst_ack) begin
          state_d = IDLE;
          ready_d = 1'b0;
          fault_d = 1'b0;
          cause_d = FAULT_NONE;
          if (!abort && rd_ok) begin
            state_d = REQ;
            addr_d = rd_addr;
            valid_d = 1'b1;
          end else if (!abort && rd_bad) begin
            state_d = HOLD;
            ready_d = 1'b1;
            fault_d = 1'b1;
            cause_d = FAULT_MISALIGN;
            data_d = DATA_W'(INST_NOP);
          end
        end
      end
      DISCARD: begin
        pend_d = rd_ok | (pend_q & !abort);
        pend_addr_d = rd_ok ? rd_addr : pend_addr_q;
        if (mem_rsp_valid || expire) begin
          state_d = pend_d ? REQ : IDLE;
          valid_d = pend_d;
          addr_d = pend_d ? pend_addr_d : addr_q;
          pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      pend_addr_q <= '0;
      data_q <= DATA_W'(INST_NOP);
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= FAULT_NONE;
      discard_q <= 1'b0;
      pend_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      addr_q <= addr_d;
      pend_addr_q <= pend_addr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
      discard_q <= discard_d;
      pend_q <= pend_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign inst_data = data_q;
  assign inst_ready = ready_q;
  assign inst_fault = fault_q;
  assign fault_cause = cause_q;
  assign mem_req_valid = valid_q;
  assign mem_req_addr = addr_q;
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// tb_inst_fetch_bridge: directed scenario bench for inst_fetch_bridge with TIMEOUT = 8
module tb_inst_fetch_bridge;
  logic clk = 1'b0, rst, clk_en, inst_rd_en, inst_ack, abort;
  logic [31:0] inst_addr, inst_data, mem_req_addr, mem_rsp_data;
  logic inst_ready, inst_fault, mem_req_valid, mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [1:0] fault_cause;
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] NOP = 32'h00000013;
  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .inst_addr(inst_addr), .inst_rd_en(inst_rd_en),
    .inst_ack(inst_ack), .abort(abort), .inst_data(inst_data), .inst_ready(inst_ready),
    .inst_fault(inst_fault), .fault_cause(fault_cause), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1; clk_en = 0; inst_rd_en = 0; inst_ack = 0; abort = 0; inst_addr = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    tick(); tick();
    rst = 0; clk_en = 1;
    n_cmp++; if (inst_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", inst_ready); end
    n_cmp++; if (inst_data !== NOP) begin n_err++; $display("FAIL rst_data: got %h want %h", inst_data, NOP); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_req_addr); end
    n_cmp++; if ({inst_fault, fault_cause} !== 3'b000) begin n_err++; $display("FAIL rst_fault: got %b%b want 000", inst_fault, fault_cause); end
  endtask
  task automatic test_zero_wait();
    inst_addr = 32'h100; inst_rd_en = 1; mem_req_ready = 1;
    tick();
    inst_rd_en = 0;
    n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL zw_req: got %b/%h want 1/00000100", mem_req_valid, mem_req_addr); end
    tick();
    n_cmp++; if ({mem_req_valid, inst_ready} !== 2'b00) begin n_err++; $display("FAIL zw_wait: got valid %b ready %b want 0 0", mem_req_valid, inst_ready); end
    mem_rsp_valid = 1; mem_rsp_data = 32'h00500093;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if (inst_ready !== 1'b1) begin n_err++; $display("FAIL zw_ready_c3: got %b want 1", inst_ready); end
    n_cmp++; if ({inst_fault, inst_data} !== {1'b0, 32'h00500093}) begin n_err++; $display("FAIL zw_data: got %b/%h want 0/00500093", inst_fault, inst_data); end
    inst_ack = 1; inst_rd_en = 1; inst_addr = 32'h104;
    tick();
    inst_ack = 0; inst_rd_en = 0;
    n_cmp++; if ({inst_ready, mem_req_valid, mem_req_addr} !== {2'b01, 32'h104}) begin n_err++; $display("FAIL b2b_req: got ready %b valid %b addr %h want 0 1 00000104", inst_ready, mem_req_valid, mem_req_addr); end
    tick();
    mem_rsp_valid = 1; mem_rsp_data = 32'h00100113;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if ({inst_ready, inst_data} !== {1'b1, 32'h00100113}) begin n_err++; $display("FAIL b2b_data: got %b/%h want 1/00100113", inst_ready, inst_data); end
    inst_ack = 1; mem_req_ready = 0;
    tick();
    inst_ack = 0;
    n_cmp++; if (inst_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ack: got %b want 0", inst_ready); end
  endtask
  task automatic test_req_stall_abort();
    inst_addr = 32'h300; inst_rd_en = 1; mem_req_ready = 0;
    tick();
    inst_rd_en = 0;
    for (int i = 0; i < 4; i++) begin
      abort = (i == 1);
      n_cmp++; if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL stall_req%0d: got %b/%h want 1/00000300", i, mem_req_valid, mem_req_addr); end
      tick();
    end
    abort = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_accept: got %b want 0", mem_req_valid); end
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if (inst_ready !== 1'b0) begin n_err++; $display("FAIL stall_drop: got %b want 0", inst_ready); end
    tick(); tick();
    n_cmp++; if ({inst_ready, mem_req_valid} !== 2'b00) begin n_err++; $display("FAIL stall_idle: got ready %b valid %b want 0 0", inst_ready, mem_req_valid); end
  endtask
  task automatic test_discard_redirect();
    inst_addr = 32'h400; inst_rd_en = 1; mem_req_ready = 1;
    tick();
    inst_rd_en = 0;
    tick();
    mem_req_ready = 0; abort = 1;
    tick();
    abort = 0; inst_rd_en = 1; inst_addr = 32'h200;
    tick();
    inst_rd_en = 0;
    n_cmp++; if ({inst_ready, mem_req_valid} !== 2'b00) begin n_err++; $display("FAIL disc_hold: got ready %b valid %b want 0 0", inst_ready, mem_req_valid); end
    mem_rsp_valid = 1; mem_rsp_data = 32'hBAD0BAD0;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if ({inst_ready, mem_req_valid, mem_req_addr} !== {2'b01, 32'h200}) begin n_err++; $display("FAIL disc_reissue: got ready %b valid %b addr %h want 0 1 00000200", inst_ready, mem_req_valid, mem_req_addr); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h00200193;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if ({inst_ready, inst_data} !== {1'b1, 32'h00200193}) begin n_err++; $display("FAIL disc_data: got %b/%h want 1/00200193", inst_ready, inst_data); end
    inst_ack = 1;
    tick();
    inst_ack = 0;
  endtask
  task automatic test_timeout();
    inst_addr = 32'h500; inst_rd_en = 1; mem_req_ready = 1;
    tick();
    inst_rd_en = 0;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (inst_ready !== 1'b0) begin n_err++; $display("FAIL to_early%0d: got %b want 0", i, inst_ready); end
      tick();
    end
    n_cmp++; if ({inst_ready, inst_fault, fault_cause} !== 4'b1111) begin n_err++; $display("FAIL to_fault: got ready %b fault %b cause %0d want 1 1 3", inst_ready, inst_fault, fault_cause); end
    n_cmp++; if (inst_data !== NOP) begin n_err++; $display("FAIL to_data: got %h want %h", inst_data, NOP); end
    inst_ack = 1;
    tick();
    inst_ack = 0;
  endtask
  task automatic test_misalign();
    inst_addr = 32'h102; inst_rd_en = 1;
    tick();
    inst_rd_en = 0;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_noreq: got %b want 0", mem_req_valid); end
    n_cmp++; if ({inst_ready, inst_fault, fault_cause} !== 4'b1101) begin n_err++; $display("FAIL mis_fault: got ready %b fault %b cause %0d want 1 1 1", inst_ready, inst_fault, fault_cause); end
    n_cmp++; if (inst_data !== NOP) begin n_err++; $display("FAIL mis_data: got %h want %h", inst_data, NOP); end
    inst_ack = 1;
    tick();
    inst_ack = 0;
    n_cmp++; if ({inst_ready, inst_fault} !== 2'b00) begin n_err++; $display("FAIL mis_ack: got ready %b fault %b want 0 0", inst_ready, inst_fault); end
  endtask
  task automatic test_bus_err_clk_en();
    inst_addr = 32'h600; inst_rd_en = 1; mem_req_ready = 1;
    tick();
    inst_rd_en = 0;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_data = 32'h12345678;
    tick();
    mem_rsp_valid = 0; mem_rsp_err = 0;
    n_cmp++; if ({inst_ready, inst_fault, fault_cause} !== 4'b1110) begin n_err++; $display("FAIL bus_fault: got ready %b fault %b cause %0d want 1 1 2", inst_ready, inst_fault, fault_cause); end
    n_cmp++; if (inst_data !== 32'h12345678) begin n_err++; $display("FAIL bus_data: got %h want 12345678", inst_data); end
    clk_en = 0; inst_ack = 1; abort = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({inst_ready, inst_fault, fault_cause, mem_req_valid, inst_data} !== {5'b11100, 32'h12345678}) begin n_err++; $display("FAIL freeze%0d: got ready %b fault %b cause %0d valid %b data %h", i, inst_ready, inst_fault, fault_cause, mem_req_valid, inst_data); end
    end
    clk_en = 1; abort = 0;
    tick();
    inst_ack = 0;
    n_cmp++; if (inst_ready !== 1'b0) begin n_err++; $display("FAIL thaw_ack: got %b want 0", inst_ready); end
  endtask
  task automatic test_reset_mid();
    inst_addr = 32'h700; inst_rd_en = 1; mem_req_ready = 1;
    tick();
    inst_rd_en = 0;
    tick();
    mem_req_ready = 0; rst = 1;
    tick();
    rst = 0;
    n_cmp++; if ({inst_ready, mem_req_valid, inst_data} !== {2'b00, NOP}) begin n_err++; $display("FAIL rstmid: got ready %b valid %b data %h want 0 0 %h", inst_ready, mem_req_valid, inst_data, NOP); end
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFEF00D;
    tick();
    mem_rsp_valid = 0;
    n_cmp++; if ({inst_ready, inst_data} !== {1'b0, NOP}) begin n_err++; $display("FAIL rstmid_stale: got %b/%h want 0/%h", inst_ready, inst_data, NOP); end
  endtask
  initial begin
    test_reset();
    test_zero_wait();
    test_req_stall_abort();
    test_discard_redirect();
    test_timeout();
    test_misalign();
    test_bus_err_clk_en();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/inst_fetch_bridge.md
Name: inst_fetch_bridge

Overview:
- Instruction-side bus bridge between the core's fetch port (inst_addr / inst_rd_en / inst_data / inst_ready) and a valid/ready instruction memory bus.
- Sits directly upstream of instruction_fetch and supplies the instruction word and ready flag the control block uses to stall IF_ID.
- One outstanding request at a time, one-entry response hold register, discard of in-flight responses on redirect, and a bus-timeout watchdog that raises a fetch fault.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, instruction word width (RV32I, fixed at 32).
- TIMEOUT, 255, cycles in WAIT/DISCARD before a timeout fault is declared; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  clock enable; when low, all state and outputs are frozen.
- inst_addr  in  ADDR_W  fetch address from the core (dataBus_u).
- inst_rd_en  in  1  fetch request from the core.
- inst_ack  in  1  core consumed the held instruction (IF_ID advanced).
- abort  in  1  PC redirect/flush; cancels the current fetch.
- inst_data  out  DATA_W  instruction to the core (instruction_u).
- inst_ready  out  1  inst_data valid.
- inst_fault  out  1  fetch fault qualifies inst_data.
- fault_cause  out  2  fetchFault_e.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_addr  out  ADDR_W  word-aligned request address.
- mem_rsp_valid  in  1  response valid; always accepted, with no backpressure.
- mem_rsp_data  in  DATA_W  response data.
- mem_rsp_err  in  1  bus error on the response.

Behaviour:
- Reset, when rst is sampled high on a clk edge with clk_en ignored:
  - state = IDLE.
  - mem_req_valid = 0, mem_req_addr = 0.
  - inst_data = NOP (0x00000013), inst_ready = 0, inst_fault = 0, fault_cause = FAULT_NONE.
  - Timeout counter = 0, pending flag = 0.
- All outputs are registered.
- IDLE:
  - inst_rd_en with inst_addr[1:0] != 0 -> HOLD with inst_fault = 1, cause = MISALIGN, inst_data = NOP. No bus request is issued.
  - inst_rd_en with an aligned address -> latch the address, go to REQ, mem_req_valid = 1 on the next cycle.
- REQ:
  - mem_req_valid stays high and mem_req_addr stays stable until mem_req_ready. mem_req_valid is never dropped before acceptance, even on abort.
  - Acceptance -> WAIT, valid cleared, counter cleared.
  - Abort seen in REQ sets the discard flag; acceptance then goes to DISCARD instead of WAIT.
- WAIT:
  - mem_rsp_valid -> HOLD. inst_data = mem_rsp_data. inst_fault = mem_rsp_err, cause = BUS if mem_rsp_err.
  - Counter reaching TIMEOUT -> HOLD, inst_fault = 1, cause = TIMEOUT, inst_data = NOP.
  - Abort -> DISCARD.
- HOLD:
  - inst_ready = 1; inst_data and inst_fault are held until inst_ack or abort.
  - inst_ack together with inst_rd_en (aligned) -> latch the new address and go directly to REQ (back-to-back, 1 bubble).
  - inst_ack without inst_rd_en -> IDLE.
  - Abort -> IDLE, inst_ready cleared next cycle.
- DISCARD:
  - The next mem_rsp_valid is dropped (inst_ready stays 0).
  - Watchdog timeout also exits DISCARD.
  - If inst_rd_en was seen during DISCARD, the address is latched into the pending register; exit then goes to REQ, otherwise to IDLE.
- Simultaneous events:
  - abort with mem_rsp_valid in WAIT -> the response is discarded, go to IDLE.
  - abort with inst_ack in HOLD -> abort wins.
- mem_rsp_valid outside WAIT/DISCARD is ignored. A sticky protocol-error flag is kept for debug only and is not a port.
- The counter saturates at TIMEOUT and has width $clog2(TIMEOUT+1).
- Request-to-ready latency: 1 cycle to REQ + bus wait + 1 cycle capture. Zero-wait bus: inst_rd_en at cycle 0 -> inst_ready at cycle 3.
- Reset mid-operation: returns to IDLE immediately. An in-flight bus response after reset is ignored per the rule above.

Decomposition:
- Shared riscv package gains:
  - fetchFault_e {FAULT_NONE, FAULT_MISALIGN, FAULT_BUS, FAULT_TIMEOUT}.
  - ifbState_e {IDLE, REQ, WAIT, HOLD, DISCARD}.
  - Constant INST_NOP = 32'h00000013.
- The existing dataBus_u / instruction_u types are reused.
- One sub-module: ifb_watchdog (clear, enable, expire; saturating counter). The FSM and hold register stay in the top module.

Test Plan:
- Zero-wait bus, fetch at 0x100, mem_rsp_data = 0x00500093 -> inst_ready at cycle 3, inst_data = 0x00500093, inst_fault = 0. inst_ack with new addr 0x104 -> mem_req_valid next cycle with addr 0x104.
- mem_req_ready held low 4 cycles with abort pulsed in cycle 2 -> mem_req_valid/addr stable all 4 cycles; after acceptance the response 0xDEADBEEF is dropped and inst_ready never rises.
- Abort in WAIT, new inst_rd_en addr 0x200 during DISCARD -> stale response dropped, then request for 0x200 issued, inst_data = the 0x200 response.
- TIMEOUT = 8, no response -> after 8 WAIT cycles inst_ready = 1, inst_fault = 1, cause = FAULT_TIMEOUT, inst_data = 0x00000013.
- Fetch at 0x102 -> no mem_req_valid, inst_ready = 1 after 1 cycle, cause = FAULT_MISALIGN. Separately, mem_rsp_err = 1 -> cause = FAULT_BUS.
- clk_en = 0 for 5 cycles in HOLD -> all outputs frozen. rst asserted in WAIT -> next cycle IDLE, inst_ready = 0, inst_data = NOP.
